// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 16x-oversampled UART receiver with single-entry holding register; optional even parity via UART_RX_PARITY_EN
module uart_rx_byte #(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD = 19200,
  parameter int DBITS = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx,
  input  logic             rd,
  output logic [DBITS-1:0] dout,
  output logic             rx_valid,
  output logic             frame_err,
  output logic             overrun,
  output logic             parity_err,
  output logic             busy
);
  localparam int DIV = CLK_HZ / (BAUD * 16);
  localparam int CW = DIV > 1 ? $clog2(DIV) : 1;
  localparam int BW = $clog2(DBITS);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;
  logic s1, rxs, rxp;
  logic [CW-1:0] cnt;
  logic tick, fall;
  logic [3:0] sc, sc_n;
  logic [BW-1:0] bc, bc_n;
  logic [DBITS-1:0] shift, shift_n;
  logic stop_s, stop_s_n, done, done_n, load;
`ifdef UART_RX_PARITY_EN
  logic par_s, par_s_n, perr;
`endif
  assign tick = cnt == CW'(DIV - 1);
  assign fall = rxp && !rxs;
  assign busy = state != IDLE;
  assign load = done && (!rx_valid || rd);
  // two-flop synchroniser plus one delayed copy for falling-edge detection
  always_ff @(posedge clk)
    if (reset) {s1, rxs, rxp} <= 3'b111;
    else {s1, rxs, rxp} <= {rx, s1, rxs};
  // oversample tick divider, re-phased on start-bit detection so samples land mid-bit
  always_ff @(posedge clk)
    if (reset || (state == IDLE && fall) || tick) cnt <= '0;
    else cnt <= cnt + 1'b1;
  // frame FSM state and datapath registers
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      sc <= '0;
      bc <= '0;
      shift <= '0;
      stop_s <= 1'b0;
      done <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_s <= 1'b0;
`endif
    end else begin
      state <= state_n;
      sc <= sc_n;
      bc <= bc_n;
      shift <= shift_n;
      stop_s <= stop_s_n;
      done <= done_n;
`ifdef UART_RX_PARITY_EN
      par_s <= par_s_n;
`endif
    end
  // next-state: START samples on its 8th tick, later bits every 16 ticks (sc wraps 15->0)
  always_comb begin
    state_n = state;
    sc_n = sc;
    bc_n = bc;
    shift_n = shift;
    stop_s_n = stop_s;
    done_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_s_n = par_s;
`endif
    case (state)
      IDLE: begin
        sc_n = '0;
        state_n = fall ? START : IDLE;
      end
      START:
        if (tick) begin
          sc_n = sc == 4'd7 ? 4'd0 : sc + 4'd1;
          bc_n = '0;
          if (sc == 4'd7) state_n = rxs ? IDLE : DATA;
        end
      DATA:
        if (tick) begin
          sc_n = sc + 4'd1;
          if (sc == 4'd15) begin
            shift_n = {rxs, shift[DBITS-1:1]};
            bc_n = bc + 1'b1;
`ifdef UART_RX_PARITY_EN
            if (bc == BW'(DBITS - 1)) state_n = PARITY;
`else
            if (bc == BW'(DBITS - 1)) state_n = STOP;
`endif
          end
        end
`ifdef UART_RX_PARITY_EN
      PARITY:
        if (tick) begin
          sc_n = sc + 4'd1;
          if (sc == 4'd15) begin
            par_s_n = rxs;
            state_n = STOP;
          end
        end
`endif
      STOP:
        if (tick) begin
          sc_n = sc + 4'd1;
          if (sc == 4'd15) begin
            stop_s_n = rxs;
            done_n = 1'b1;
            state_n = IDLE;
          end
        end
      default: state_n = IDLE;
    endcase
  end
  // holding register: load on completion if empty or being read, else drop and flag overrun
  always_ff @(posedge clk)
    if (reset) begin
      dout <= '0;
      rx_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun <= 1'b0;
    end else if (load) begin
      dout <= shift;
      rx_valid <= 1'b1;
      frame_err <= !stop_s;
      overrun <= overrun && !rd;
    end else if (done) begin
      overrun <= 1'b1;
    end else if (rd && rx_valid) begin
      rx_valid <= 1'b0;
      overrun <= 1'b0;
    end
`ifdef UART_RX_PARITY_EN
  // parity status travels with the byte in dout
  always_ff @(posedge clk)
    if (reset) perr <= 1'b0;
    else if (load) perr <= (^shift) ^ par_s;
  assign parity_err = perr;
`else
  assign parity_err = 1'b0;
`endif
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: directed checks of the UART receiver at DIV=10 (160 clk per bit)
module tb_uart_rx_byte;
  logic clk = 1'b0, reset = 1'b1, rx = 1'b1, rd = 1'b0;
  logic [7:0] dout;
  logic rx_valid, frame_err, overrun, parity_err, busy;
  int checks = 0, errors = 0;
`ifdef UART_RX_PARITY_EN
  localparam bit PB = 1'b1;
`else
  localparam bit PB = 1'b0;
`endif
  uart_rx_byte #(.CLK_HZ(1_600_000), .BAUD(10_000), .DBITS(8)) dut (
    .clk(clk), .reset(reset), .rx(rx), .rd(rd), .dout(dout), .rx_valid(rx_valid),
    .frame_err(frame_err), .overrun(overrun), .parity_err(parity_err), .busy(busy)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic bit_time(input logic v);
    rx = v;
    repeat (160) @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [7:0] d, input logic par, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time(d[i]);
    if (PB) bit_time(par);
    bit_time(stop);
  endtask
  task automatic idle(input int n);
    rx = 1'b1;
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic pulse_rd;
    rd = 1'b1;
    step;
    rd = 1'b0;
  endtask
  initial begin
    int n;
    repeat (3) step;
    @(negedge clk);
    check("reset dout", dout, 8'h00);
    check("reset rx_valid", rx_valid, 0);
    check("reset frame_err", frame_err, 0);
    check("reset overrun", overrun, 0);
    check("reset parity_err", parity_err, 0);
    check("reset busy", busy, 0);
    step;
    reset = 1'b0;
    idle(20);
    // 1: 0x55, exact completion latency
    bit_time(1'b0);
    for (int i = 0; i < 8; i++) bit_time((i % 2) == 0);
    if (PB) bit_time(1'b0);
    rx = 1'b1;
    repeat (83) @(posedge clk);
    @(negedge clk);
    check("t1 valid before", rx_valid, 0);
    @(posedge clk);
    @(negedge clk);
    check("t1 valid after", rx_valid, 1);
    check("t1 dout", dout, 8'h55);
    check("t1 frame_err", frame_err, 0);
    check("t1 overrun", overrun, 0);
    check("t1 parity_err", parity_err, 0);
    idle(100);
    pulse_rd;
    @(negedge clk);
    check("t1 read clears", rx_valid, 0);
    step;
    // 2: overrun, then read clears it
    send(8'hA3, 1'b0, 1'b1);
    idle(20);
    send(8'h3C, 1'b0, 1'b1);
    idle(20);
    check("t2 dout kept", dout, 8'hA3);
    check("t2 valid", rx_valid, 1);
    check("t2 overrun", overrun, 1);
    pulse_rd;
    @(negedge clk);
    check("t2 valid cleared", rx_valid, 0);
    check("t2 overrun cleared", overrun, 0);
    check("t2 dout held", dout, 8'hA3);
    step;
    pulse_rd;
    @(negedge clk);
    check("t2 idle rd dout", dout, 8'hA3);
    check("t2 idle rd valid", rx_valid, 0);
    step;
    // 3: 30-clock glitch rejected
    rx = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk);
    check("t3 busy", busy, 1);
    repeat (20) @(posedge clk);
    #1;
    rx = 1'b1;
    n = 0;
    while (busy && n < 80) begin
      step;
      n++;
    end
    check("t3 busy clear", busy, 0);
    idle(200);
    check("t3 no valid", rx_valid, 0);
    // 4: framing error, then break produces nothing
    send(8'h0F, 1'b0, 1'b0);
    check("t4 dout", dout, 8'h0F);
    check("t4 valid", rx_valid, 1);
    check("t4 frame_err", frame_err, 1);
    pulse_rd;
    repeat (3200) step;
    check("t4 break valid", rx_valid, 0);
    check("t4 break busy", busy, 0);
    check("t4 frame_err held", frame_err, 1);
    check("t4 overrun", overrun, 0);
    idle(100);
    check("t4 release valid", rx_valid, 0);
    // 5: reset mid data bit 4, then clean 0x81
    bit_time(1'b0);
    bit_time(1'b1);
    for (int i = 1; i < 4; i++) bit_time(1'b0);
    rx = 1'b0;
    repeat (80) @(posedge clk);
    #1;
    check("t5 mid busy", busy, 1);
    reset = 1'b1;
    rx = 1'b1;
    step;
    @(negedge clk);
    check("t5 reset dout", dout, 8'h00);
    check("t5 reset frame_err", frame_err, 0);
    check("t5 reset valid", rx_valid, 0);
    check("t5 reset busy", busy, 0);
    check("t5 reset overrun", overrun, 0);
    step;
    reset = 1'b0;
    idle(200);
    send(8'h81, 1'b0, 1'b1);
    idle(20);
    check("t5 dout", dout, 8'h81);
    check("t5 valid", rx_valid, 1);
    check("t5 frame_err", frame_err, 0);
    check("t5 parity_err", parity_err, 0);
    pulse_rd;
`ifdef UART_RX_PARITY_EN
    // 6: even parity, 0x07 needs parity bit 1
    idle(20);
    send(8'h07, 1'b0, 1'b1);
    idle(20);
    check("t6 bad dout", dout, 8'h07);
    check("t6 bad parity_err", parity_err, 1);
    pulse_rd;
    idle(20);
    send(8'h07, 1'b1, 1'b1);
    idle(20);
    check("t6 good valid", rx_valid, 1);
    check("t6 good parity_err", parity_err, 0);
    check("t6 good frame_err", frame_err, 0);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
